// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side (F, D) and memory_interface-side signals around mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters/memory view.
interface mem_arbiter_if #(
  parameter int IO_BITS  = 2,
  parameter int CMD_BITS = 8
);
  logic                f_req;
  logic                d_req;
  logic [CMD_BITS-1:0] f_cmd;
  logic [CMD_BITS-1:0] d_cmd;
  logic                f_rd;
  logic                d_rd;
  logic                f_gnt;
  logic                d_gnt;
  logic [IO_BITS-1:0]  f_tx_data;
  logic [IO_BITS-1:0]  d_tx_data;
  logic                f_tx_next;
  logic                d_tx_next;
  logic                f_rx_valid;
  logic                d_rx_valid;
  logic                f_done;
  logic                d_done;
  logic                m_cmd_valid;
  logic [CMD_BITS-1:0] m_cmd;
  logic                m_cmd_started;
  logic [IO_BITS-1:0]  m_tx_data;
  logic                m_tx_next;
  logic                m_tx_done;
  logic                m_rx_data_valid;
  logic                m_rx_done;
  logic                owner;
  logic                busy;

  modport slave (
    input  f_req, d_req, f_cmd, d_cmd, f_rd, d_rd, f_tx_data, d_tx_data,
    input  m_cmd_started, m_tx_next, m_tx_done, m_rx_data_valid, m_rx_done,
    output f_gnt, d_gnt, f_tx_next, d_tx_next, f_rx_valid, d_rx_valid, f_done, d_done,
    output m_cmd_valid, m_cmd, m_tx_data, owner, busy
  );

  modport master (
    output f_req, d_req, f_cmd, d_cmd, f_rd, d_rd, f_tx_data, d_tx_data,
    output m_cmd_started, m_tx_next, m_tx_done, m_rx_data_valid, m_rx_done,
    input  f_gnt, d_gnt, f_tx_next, d_tx_next, f_rx_valid, d_rx_valid, f_done, d_done,
    input  m_cmd_valid, m_cmd, m_tx_data, owner, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory_interface TX/RX channel between fetch (F) and decoder data (D).
// D has priority; after STARVE_LIMIT consecutive D grants with F waiting, F wins once.
module mem_arbiter #(
  parameter int IO_BITS      = 2,
  parameter int CMD_BITS     = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, CMD, TX, RX} state_t;

  state_t              state;
  state_t              state_nxt;
  logic                owner_q;
  logic                rd_lat;
  logic [STREAK_W-1:0] streak;
  logic [CMD_BITS-1:0] cmd_q;
  logic                f_done_q;
  logic                d_done_q;
  logic                grant;
  logic                win_d;
  logic                done_nxt;
  logic                starve;
  logic                tx_phase;
  logic                rx_phase;

  assign starve = bus.f_req && (streak == STREAK_W'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Grants are held off while reset is asserted so a held request cannot leak a gnt pulse.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    win_d     = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && bus.d_req && !starve) begin
          grant     = 1'b1;
          win_d     = 1'b1;
          state_nxt = CMD;
        end else if (rst_n && bus.f_req) begin
          grant     = 1'b1;
          state_nxt = CMD;
        end
      end
      CMD: if (bus.m_cmd_started) state_nxt = TX;
      TX: begin
        if (bus.m_tx_done) begin
          if (!rd_lat || bus.m_rx_done) begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = RX;
          end
        end
      end
      RX: begin
        if (bus.m_rx_done) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Streak counts D wins that happened while F was waiting; any F win or idle F clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= 1'b0;
      rd_lat   <= 1'b0;
      streak   <= '0;
      cmd_q    <= '0;
      f_done_q <= 1'b0;
      d_done_q <= 1'b0;
    end else begin
      f_done_q <= done_nxt && !owner_q;
      d_done_q <= done_nxt && owner_q;
      if (grant) begin
        owner_q <= win_d;
        cmd_q   <= win_d ? bus.d_cmd : bus.f_cmd;
        rd_lat  <= win_d ? bus.d_rd  : bus.f_rd;
        if (win_d && bus.f_req) begin
          if (streak != STREAK_W'(STARVE_LIMIT)) streak <= streak + STREAK_W'(1);
        end else begin
          streak <= '0;
        end
      end
    end
  end

  assign tx_phase = (state == CMD) || (state == TX);
  assign rx_phase = (state == TX)  || (state == RX);

  assign bus.f_gnt       = grant && !win_d;
  assign bus.d_gnt       = grant && win_d;
  assign bus.m_cmd_valid = (state == CMD);
  assign bus.m_cmd       = cmd_q;
  assign bus.m_tx_data   = owner_q ? bus.d_tx_data : bus.f_tx_data;
  assign bus.f_tx_next   = bus.m_tx_next && !owner_q && tx_phase;
  assign bus.d_tx_next   = bus.m_tx_next && owner_q && tx_phase;
  assign bus.f_rx_valid  = bus.m_rx_data_valid && !owner_q && rx_phase;
  assign bus.d_rx_valid  = bus.m_rx_data_valid && owner_q && rx_phase;
  assign bus.f_done      = f_done_q;
  assign bus.d_done      = d_done_q;
  assign bus.owner       = owner_q;
  assign bus.busy        = (state != IDLE);

endmodule
